// File: rtl/mlp_eval_pkg.sv
// Purpose: shared types, default parameters and helpers for the MLP evaluation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mlp_eval_pkg;

  localparam int DEF_NUM_A         = 7;
  localparam int DEF_WIDTH_A       = 4;
  localparam int DEF_OUTWIDTH      = 2;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Extract channel idx from a sample bus laid out at the default geometry.
  function automatic logic [DEF_WIDTH_A-1:0] chan_slice(
    input logic [DEF_NUM_A*DEF_WIDTH_A-1:0] bus,
    input int                               idx
  );
    return bus[idx*DEF_WIDTH_A +: DEF_WIDTH_A];
  endfunction

endpackage

// File: rtl/mlp_eval_sequencer_sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping; clear beats increment.
// Latency: q updates one clock after inc/clr.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  // Count events, holding at the maximum; a clear in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX_VAL)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mlp_eval_sequencer.sv
// Purpose: feeds masked samples to a combinational classifier, samples its class after a settle time, scores it.
// Latency: r_valid rises SETTLE_CYCLES clocks after the accept edge; one sample per SETTLE_CYCLES+2 clocks.
// Backpressure: result is held until r_ready; no new sample is accepted until the result is taken.
module mlp_eval_sequencer
  import mlp_eval_pkg::*;
#(
  parameter int NUM_A         = DEF_NUM_A,
  parameter int WIDTH_A       = DEF_WIDTH_A,
  parameter int OUTWIDTH      = DEF_OUTWIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [NUM_A*WIDTH_A-1:0]   s_data,
  input  logic [OUTWIDTH-1:0]        s_label,
  input  logic [NUM_A-1:0]           chan_mask,
  output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
  input  logic [OUTWIDTH-1:0]        mlp_out,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [OUTWIDTH-1:0]        r_pred,
  output logic [OUTWIDTH-1:0]        r_label,
  output logic                       r_match,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           cnt_total,
  output logic [CNT_W-1:0]           cnt_correct,
  output logic                       busy
);

  localparam int                SW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]     CNT_INIT = SW'(SETTLE_CYCLES - 1);

  state_t                     state;
  logic [SW-1:0]              settle_cnt;
  logic [OUTWIDTH-1:0]        label_q;
  logic [NUM_A*WIDTH_A-1:0]   masked;
  logic                       res_hs;

  // Disabled ADC channels are presented to the classifier as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_A; gi++) begin : g_mask
      assign masked[gi*WIDTH_A +: WIDTH_A] =
        chan_mask[gi] ? s_data[gi*WIDTH_A +: WIDTH_A] : '0;
    end
  endgenerate

  assign s_ready = (state == IDLE);
  assign busy    = (state != IDLE);
  assign res_hs  = r_valid && r_ready;

  // Sequencer: latch sample, count out the settle time, capture the class, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      label_q    <= '0;
      mlp_inp    <= '0;
      r_valid    <= 1'b0;
      r_pred     <= '0;
      r_label    <= '0;
      r_match    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            mlp_inp    <= masked;
            label_q    <= s_label;
            settle_cnt <= CNT_INIT;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            r_pred  <= mlp_out;
            r_label <= label_q;
            r_match <= (mlp_out == label_q);
            r_valid <= 1'b1;
            state   <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        HOLD: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (res_hs),
    .clr   (cnt_clr),
    .q     (cnt_total)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_correct (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (res_hs && r_match),
    .clr   (cnt_clr),
    .q     (cnt_correct)
  );

endmodule

// File: tb/tb_mlp_eval_sequencer.sv
module tb_mlp_eval_sequencer;
  import mlp_eval_pkg::*;

  localparam int NA = 7, WA = 4, OW = 2, SC = 3, DW = NA * WA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid, r_ready, cnt_clr;
  logic [DW-1:0] s_data;
  logic [OW-1:0] s_label;
  logic [NA-1:0] chan_mask;

  logic          s_ready, r_valid, r_match, busy;
  logic [DW-1:0] mlp_inp;
  logic [OW-1:0] mlp_out, r_pred, r_label;
  logic [15:0]   cnt_total, cnt_correct;

  logic          s_ready2, r_valid2, r_match2, busy2;
  logic [DW-1:0] mlp_inp2;
  logic [OW-1:0] mlp_out2, r_pred2, r_label2;
  logic [1:0]    cnt_total2, cnt_correct2;

  // Classifier stubs: class = low two bits of the input bus.
  assign mlp_out  = mlp_inp[1:0];
  assign mlp_out2 = mlp_inp2[1:0];

  mlp_eval_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_label(s_label), .chan_mask(chan_mask), .mlp_inp(mlp_inp), .mlp_out(mlp_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_pred(r_pred), .r_label(r_label),
    .r_match(r_match), .cnt_clr(cnt_clr), .cnt_total(cnt_total),
    .cnt_correct(cnt_correct), .busy(busy)
  );

  mlp_eval_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_label(s_label), .chan_mask(chan_mask), .mlp_inp(mlp_inp2), .mlp_out(mlp_out2),
    .r_valid(r_valid2), .r_ready(r_ready), .r_pred(r_pred2), .r_label(r_label2),
    .r_match(r_match2), .cnt_clr(cnt_clr), .cnt_total(cnt_total2),
    .cnt_correct(cnt_correct2), .busy(busy2)
  );

  int vectors = 0, miscompares = 0;
  int tot_m = 0, cor_m = 0, tot2_m = 0, cor2_m = 0;

  typedef struct packed {
    logic [DW-1:0] inp;
    logic [OW-1:0] label;
  } exp_t;

  // Reference: sum of enabled channels placed back at their positions.
  function automatic logic [DW-1:0] mask_ref(input logic [DW-1:0] d, input logic [NA-1:0] m);
    logic [DW-1:0] res = '0;
    for (int i = 0; i < NA; i++)
      if (m[i]) res = res + (DW'(chan_slice(d, i)) << (i * WA));
    return res;
  endfunction

  task automatic model_hs(input logic match, input logic clr);
    if (clr) begin
      tot_m = 0; cor_m = 0; tot2_m = 0; cor2_m = 0;
    end else begin
      if (tot_m < 65535) tot_m++;
      if (match && cor_m < 65535) cor_m++;
      if (tot2_m < 3) tot2_m++;
      if (match && cor2_m < 3) cor2_m++;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [OW-1:0] l, input logic [NA-1:0] m);
    @(negedge clk);
    s_data = d; s_label = l; chan_mask = m; s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chan_mask = NA'($urandom);
    s_data = DW'($urandom);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (r_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (r_valid !== 1'b1) cyc = -1;
  endtask

  task automatic handshake(input logic exp_match, input logic clr);
    r_ready = 1'b1; cnt_clr = clr;
    @(posedge clk);
    @(negedge clk);
    r_ready = 1'b0; cnt_clr = 1'b0;
    model_hs(exp_match, clr);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1 || r_valid !== 1'b0 || mlp_inp !== '0 || cnt_total !== '0 ||
        cnt_correct !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: s_ready=%b r_valid=%b mlp_inp=%h total=%0d correct=%0d busy=%b, want 1 0 0 0 0 0",
               s_ready, r_valid, mlp_inp, cnt_total, cnt_correct, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat;
    send(28'h0000003, 2'd3, 7'h7F);
    wait_result(lat);
    vectors++;
    if (lat !== SC) begin miscompares++; $display("FAIL single_latency: got %0d want %0d", lat, SC); end
    vectors++;
    if (r_pred !== 2'd3 || r_match !== 1'b1 || r_label !== 2'd3) begin
      miscompares++;
      $display("FAIL single_result: pred=%0d match=%b label=%0d want 3 1 3", r_pred, r_match, r_label);
    end
    handshake(1'b1, 1'b0);
    vectors++;
    if (cnt_total !== 16'd1 || cnt_correct !== 16'd1 || r_valid !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_counters: total=%0d correct=%0d r_valid=%b s_ready=%b want 1 1 0 1",
               cnt_total, cnt_correct, r_valid, s_ready);
    end
  endtask

  task automatic test_mask;
    int lat;
    send(28'h0000002, 2'd2, 7'h7E);
    wait_result(lat);
    vectors++;
    if (lat !== SC || mlp_inp !== '0 || r_pred !== 2'd0 || r_match !== 1'b0) begin
      miscompares++;
      $display("FAIL mask: lat=%0d mlp_inp=%h pred=%0d match=%b want %0d 0 0 0", lat, mlp_inp, r_pred, r_match, SC);
    end
    handshake(1'b0, 1'b0);
    vectors++;
    if (cnt_total !== 16'(tot_m) || cnt_correct !== 16'(cor_m)) begin
      miscompares++;
      $display("FAIL mask_counters: total=%0d correct=%0d want %0d %0d", cnt_total, cnt_correct, tot_m, cor_m);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [DW-1:0] d1, d2, e1, e2;
    logic [OW-1:0] l1, l2;
    logic [NA-1:0] m1, m2;
    d1 = DW'($urandom); l1 = OW'($urandom); m1 = NA'($urandom);
    d2 = DW'($urandom); l2 = OW'($urandom); m2 = NA'($urandom);
    e1 = mask_ref(d1, m1); e2 = mask_ref(d2, m2);
    send(d1, l1, m1);
    wait_result(lat);
    vectors++;
    if (lat !== SC) begin miscompares++; $display("FAIL bp_latency: got %0d want %0d", lat, SC); end
    s_valid = 1'b1; s_data = d2; s_label = l2; chan_mask = m2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (r_valid !== 1'b1 || r_pred !== e1[1:0] || r_label !== l1 || r_match !== (e1[1:0] == l1) ||
          s_ready !== 1'b0 || mlp_inp !== e1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b pred=%0d label=%0d match=%b s_ready=%b inp=%h want 1 %0d %0d %b 0 %h",
                 i, r_valid, r_pred, r_label, r_match, s_ready, mlp_inp, e1[1:0], l1, e1[1:0] == l1, e1);
      end
    end
    handshake(e1[1:0] == l1, 1'b0);
    vectors++;
    if (s_ready !== 1'b1 || mlp_inp !== e1) begin
      miscompares++;
      $display("FAIL bp_second_ignored: s_ready=%b inp=%h want 1 %h", s_ready, mlp_inp, e1);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chan_mask = NA'($urandom);
    wait_result(lat);
    vectors++;
    if (lat !== SC || mlp_inp !== e2 || r_pred !== e2[1:0] || r_label !== l2) begin
      miscompares++;
      $display("FAIL bp_second: lat=%0d inp=%h pred=%0d label=%0d want %0d %h %0d %0d",
               lat, mlp_inp, r_pred, r_label, SC, e2, e2[1:0], l2);
    end
    handshake(e2[1:0] == l2, 1'b0);
    vectors++;
    if (cnt_total !== 16'(tot_m) || cnt_correct !== 16'(cor_m)) begin
      miscompares++;
      $display("FAIL bp_counters: total=%0d correct=%0d want %0d %0d", cnt_total, cnt_correct, tot_m, cor_m);
    end
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e, last;
    logic have_last = 1'b0;
    int last_acc = -1;
    r_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (have_last) begin
        vectors++;
        if (mlp_inp !== last.inp) begin
          miscompares++;
          $display("FAIL b2b_inp_hold: cyc %0d got %h want %h", cyc, mlp_inp, last.inp);
        end
      end
      if (r_valid === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_spurious: result at cyc %0d with nothing pending", cyc);
        end else begin
          e = q.pop_front();
          if (r_pred !== e.inp[1:0] || r_label !== e.label || r_match !== (e.inp[1:0] == e.label)) begin
            miscompares++;
            $display("FAIL b2b_result: pred=%0d label=%0d match=%b want %0d %0d %b",
                     r_pred, r_label, r_match, e.inp[1:0], e.label, e.inp[1:0] == e.label);
          end
          model_hs(e.inp[1:0] == e.label, 1'b0);
        end
      end
      if (cyc < 60) begin
        s_valid = 1'b1; s_data = DW'($urandom); s_label = OW'($urandom); chan_mask = NA'($urandom);
      end else begin
        s_valid = 1'b0;
      end
      if (s_valid && s_ready === 1'b1) begin
        e.inp = mask_ref(s_data, chan_mask); e.label = s_label;
        q.push_back(e);
        last = e; have_last = 1'b1;
        if (last_acc >= 0) begin
          vectors++;
          if (cyc - last_acc !== SC + 2) begin
            miscompares++;
            $display("FAIL b2b_throughput: spacing %0d want %0d", cyc - last_acc, SC + 2);
          end
        end
        last_acc = cyc;
      end
    end
    r_ready = 1'b0;
    vectors++;
    if (q.size() != 0 || cnt_total !== 16'(tot_m) || cnt_correct !== 16'(cor_m)) begin
      miscompares++;
      $display("FAIL b2b_drain: pending=%0d total=%0d correct=%0d want 0 %0d %0d",
               q.size(), cnt_total, cnt_correct, tot_m, cor_m);
    end
  endtask

  task automatic test_saturation_clear;
    int lat;
    logic [DW-1:0] d;
    logic [OW-1:0] l;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    model_hs(1'b0, 1'b1);
    vectors++;
    if (cnt_total !== '0 || cnt_correct !== '0 || cnt_total2 !== '0 || cnt_correct2 !== '0) begin
      miscompares++;
      $display("FAIL clr_idle: %0d %0d %0d %0d want all 0", cnt_total, cnt_correct, cnt_total2, cnt_correct2);
    end
    for (int i = 0; i < 5; i++) begin
      l = OW'($urandom);
      d = DW'($urandom) & 28'hFFFFFFC | DW'(l);
      send(d, l, 7'h7F);
      wait_result(lat);
      vectors++;
      if (lat !== SC || r_match !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_sample[%0d]: lat=%0d match=%b want %0d 1", i, lat, r_match, SC);
      end
      handshake(1'b1, 1'b0);
    end
    vectors++;
    if (cnt_total !== 16'd5 || cnt_correct !== 16'd5 || cnt_total2 !== 2'd3 || cnt_correct2 !== 2'd3 ||
        cnt_total2 !== 2'(tot2_m)) begin
      miscompares++;
      $display("FAIL saturation: total=%0d correct=%0d total2=%0d correct2=%0d want 5 5 3 3",
               cnt_total, cnt_correct, cnt_total2, cnt_correct2);
    end
    send(28'h0000001, 2'd1, 7'h7F);
    wait_result(lat);
    handshake(1'b1, 1'b1);
    vectors++;
    if (cnt_total !== '0 || cnt_correct !== '0 || cnt_total2 !== '0 || cnt_correct2 !== '0 ||
        r_valid !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_on_handshake: %0d %0d %0d %0d r_valid=%b s_ready=%b want 0 0 0 0 0 1",
               cnt_total, cnt_correct, cnt_total2, cnt_correct2, r_valid, s_ready);
    end
  endtask

  task automatic test_reset_mid_settle;
    int lat;
    int rises = 0;
    send(28'h0000003, 2'd3, 7'h7F);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (r_valid !== 1'b0 || mlp_inp !== '0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: r_valid=%b inp=%h s_ready=%b busy=%b want 0 0 1 0", r_valid, mlp_inp, s_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_hs(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (r_valid !== 1'b0) rises++;
    end
    vectors++;
    if (rises != 0 || cnt_total !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_drop: r_valid high %0d cycles total=%0d want 0 0", rises, cnt_total);
    end
    send(28'h0000021, 2'd1, 7'h7F);
    wait_result(lat);
    vectors++;
    if (lat !== SC || r_pred !== 2'd1 || r_match !== 1'b1 || mlp_inp !== 28'h0000021) begin
      miscompares++;
      $display("FAIL reset_mid_next: lat=%0d pred=%0d match=%b inp=%h want %0d 1 1 21", lat, r_pred, r_match, mlp_inp, SC);
    end
    handshake(1'b1, 1'b0);
    vectors++;
    if (cnt_total !== 16'(tot_m) || cnt_correct !== 16'(cor_m)) begin
      miscompares++;
      $display("FAIL reset_mid_count: total=%0d correct=%0d want %0d %0d", cnt_total, cnt_correct, tot_m, cor_m);
    end
  endtask

  initial begin
    s_valid = 1'b0; r_ready = 1'b0; cnt_clr = 1'b0;
    s_data = '0; s_label = '0; chan_mask = '1;
    test_reset;
    test_single;
    test_mask;
    test_backpressure;
    test_back_to_back;
    test_saturation_clear;
    test_reset_mid_settle;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
